// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects operand A, operand B and opcode bytes from the
// UART receiver, publishes them atomically to the ALU, captures the result one
// cycle later and sends it back through the UART transmitter.
module uart_alu_interface #(
    parameter int NB_INTERFACE_DATA = 8,
    parameter int NB_INTERFACE_OP   = 6,
    parameter int TIMEOUT_CYCLES    = 20000
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [NB_INTERFACE_DATA-1:0] i_rx_data,
    input  logic                         i_rx_done,
    input  logic [NB_INTERFACE_DATA-1:0] i_alu_res,
    input  logic                         i_tx_done,
    output logic [NB_INTERFACE_DATA-1:0] o_data_A,
    output logic [NB_INTERFACE_DATA-1:0] o_data_B,
    output logic [NB_INTERFACE_OP-1:0]   o_OP,
    output logic [NB_INTERFACE_DATA-1:0] o_tx_data,
    output logic                         o_tx_start,
    output logic                         o_timeout,
    output logic                         o_overrun
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int NB_CNT = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        LOAD_RES,
        WAIT_TX
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [NB_INTERFACE_DATA-1:0] hold_a;
    logic [NB_INTERFACE_DATA-1:0] hold_b;
    logic [NB_CNT-1:0]        idle_cnt;

    logic load_a;
    logic load_b;
    logic publish;
    logic load_res;
    logic timeout_hit;
    logic overrun_set;
    logic cnt_run;

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its sources.
        if (!i_reset_n) begin
            state <= WAIT_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control strobes; a byte always beats the timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        next_state  = state;
        load_a      = 1'b0;
        load_b      = 1'b0;
        publish     = 1'b0;
        load_res    = 1'b0;
        timeout_hit = 1'b0;
        overrun_set = 1'b0;
        cnt_run     = 1'b0;

        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    load_a     = 1'b1;
                    next_state = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    load_b     = 1'b1;
                    next_state = WAIT_OP;
                end else if (idle_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = WAIT_A;
                end else begin
                    cnt_run = 1'b1;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    publish    = 1'b1;
                    next_state = LOAD_RES;
                end else if (idle_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = WAIT_A;
                end else begin
                    cnt_run = 1'b1;
                end
            end
            LOAD_RES: begin
                load_res    = 1'b1;
                overrun_set = i_rx_done;
                next_state  = WAIT_TX;
            end
            WAIT_TX: begin
                overrun_set = i_rx_done;
                if (i_tx_done) begin
                    next_state = WAIT_A;
                end
            end
            default: begin
                next_state = WAIT_A;
            end
        endcase
    end

    // Inter-byte idle counter: runs only while waiting inside a frame.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idle_cnt <= '0;
        end else if (cnt_run) begin
            idle_cnt <= idle_cnt + NB_CNT'(1);
        end else begin
            idle_cnt <= '0;
        end
    end

    // Partial-frame holding registers; they never drive the ALU directly.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            if (load_a) hold_a <= i_rx_data;
            if (load_b) hold_b <= i_rx_data;
        end
    end

    // ALU operands and opcode change together, only when a frame completes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data_A <= '0;
            o_data_B <= '0;
            o_OP     <= '0;
        end else if (publish) begin
            o_data_A <= hold_a;
            o_data_B <= hold_b;
            o_OP     <= i_rx_data[NB_INTERFACE_OP-1:0];
        end
    end

    // Result capture and transmit request, one cycle after publishing.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= load_res;
            if (load_res) o_tx_data <= i_alu_res;
        end
    end

    // Status flags: timeout is a single-cycle pulse, overrun is sticky.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
            if (overrun_set) o_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed testbench for uart_alu_interface with a small behavioural ALU.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_alu_interface;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_res;
    logic       tx_done;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       timeout;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int timeout_seen = 0;

    uart_alu_interface #(
        .NB_INTERFACE_DATA (8),
        .NB_INTERFACE_OP   (6),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .i_alu_res  (alu_res),
        .i_tx_done  (tx_done),
        .o_data_A   (data_a),
        .o_data_B   (data_b),
        .o_OP       (op),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_timeout  (timeout),
        .o_overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stand-in: add, sub, or, else and.
    always_comb begin
        case (op)
            6'h20:   alu_res = data_a + data_b;
            6'h22:   alu_res = data_a - data_b;
            6'h25:   alu_res = data_a | data_b;
            default: alu_res = data_a & data_b;
        endcase
    end

    // Global tally of timeout pulses.
    always @(negedge clk) begin
        if (timeout) timeout_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " data_A"},   32'(data_a),   32'h0);
        check({tag, " data_B"},   32'(data_b),   32'h0);
        check({tag, " OP"},       32'(op),       32'h0);
        check({tag, " tx_data"},  32'(tx_data),  32'h0);
        check({tag, " tx_start"}, 32'(tx_start), 32'h0);
        check({tag, " timeout"},  32'(timeout),  32'h0);
        check({tag, " overrun"},  32'(overrun),  32'h0);
    endtask

    // One-cycle rx_done pulse; returns on the falling edge after capture.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // Called right after the opcode byte: checks publish, tx_start timing, completes tx.
    task automatic finish_frame(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                                input logic [5:0] eop, input logic [7:0] eres);
        check({tag, " A"},          32'(data_a),   32'(ea));
        check({tag, " B"},          32'(data_b),   32'(eb));
        check({tag, " OP"},         32'(op),       32'(eop));
        check({tag, " start@N+1"},  32'(tx_start), 32'h0);
        @(negedge clk);
        check({tag, " start@N+2"},  32'(tx_start), 32'h1);
        check({tag, " tx_data"},    32'(tx_data),  32'(eres));
        @(negedge clk);
        check({tag, " start@N+3"},  32'(tx_start), 32'h0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opb, input logic [5:0] eop, input logic [7:0] eres);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
        finish_frame(tag, a, b, eop, eres);
    endtask

    task automatic count_tx_starts(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_start) n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int idx;
        int seen_before;
        int n;

        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frames.
        run_frame("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
        run_frame("sub", 8'h03, 8'h05, 8'hE2, 6'h22, 8'hFE);
        run_frame("or",  8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF);
        check("overrun after frames", 32'(overrun), 32'h0);

        // Timeout after a lone operand A.
        send_byte(8'h11);
        pulses = 0;
        idx    = 0;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (timeout) begin
                pulses++;
                idx = i;
            end
        end
        check("timeout pulses", 32'(pulses), 32'd1);
        check("timeout cycle",  32'(idx),    32'd17);
        check("timeout keeps A",  32'(data_a), 32'hF0);
        check("timeout keeps B",  32'(data_b), 32'h0F);
        check("timeout keeps OP", 32'(op),     32'h25);
        run_frame("after timeout", 8'h01, 8'h02, 8'h20, 6'h20, 8'h03);

        // Byte on the terminal timeout cycle is accepted.
        seen_before = timeout_seen;
        send_byte(8'h11);
        repeat (14) @(negedge clk);
        send_byte(8'h22);
        repeat (3) @(negedge clk);
        check("terminal no timeout", 32'(timeout_seen - seen_before), 32'd0);
        send_byte(8'h20);
        finish_frame("terminal byte", 8'h11, 8'h22, 6'h20, 8'h33);

        // Overrun while transmitting.
        send_byte(8'h04);
        send_byte(8'h04);
        send_byte(8'h20);
        check("ovr A", 32'(data_a), 32'h04);
        @(negedge clk);
        check("ovr start", 32'(tx_start), 32'h1);
        rx_data = 8'h99;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check("ovr flag",     32'(overrun),  32'h1);
        check("ovr start off",32'(tx_start), 32'h0);
        check("ovr tx_data",  32'(tx_data),  32'h08);
        check("ovr keeps A",  32'(data_a),   32'h04);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("ovr sticky", 32'(overrun), 32'h1);
        run_frame("after ovr", 8'h07, 8'h01, 8'h22, 6'h22, 8'h06);
        check("ovr still sticky", 32'(overrun), 32'h1);

        // Reset while waiting for the opcode.
        send_byte(8'h0A);
        send_byte(8'h0B);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst wait_op");
        @(negedge clk);
        rst_n = 1'b1;
        count_tx_starts(6, n);
        check("rst wait_op no start", 32'(n), 32'd0);
        run_frame("after rst1", 8'h02, 8'h03, 8'h20, 6'h20, 8'h05);

        // Reset during the tx_start cycle, then a stray tx_done.
        send_byte(8'h09);
        send_byte(8'h01);
        send_byte(8'h20);
        @(negedge clk);
        check("rst2 start before", 32'(tx_start), 32'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst tx_start");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        count_tx_starts(6, n);
        check("rst tx no start", 32'(n), 32'd0);
        run_frame("after rst2", 8'h0C, 8'h03, 8'h25, 6'h25, 8'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
